// File: rtl/pc_unit.sv
// Program-counter unit for the fetch stage: next-PC selection with stall,
// exception/eret handling and a small circular return-address stack.
module pc_unit #(
  parameter int unsigned       WIDTH        = 32,
  parameter logic [WIDTH-1:0]  RESET_VECTOR = '0,
  parameter logic [WIDTH-1:0]  EXC_VECTOR   = WIDTH'(32'h8000_0180),
  parameter int unsigned       RAS_DEPTH    = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       stall,
  input  logic                       exception,
  input  logic                       eret,
  input  logic                       branch_taken,
  input  logic [WIDTH-1:0]           branch_target,
  input  logic                       ret,
  input  logic [WIDTH-1:0]           ret_target,
  input  logic                       jump,
  input  logic                       call,
  input  logic [WIDTH-1:0]           jump_target,
  output logic [WIDTH-1:0]           pc_out,
  output logic [WIDTH-1:0]           pc_plus4,
  output logic [WIDTH-1:0]           epc,
  output logic                       in_exception,
  output logic                       double_fault,
  output logic [$clog2(RAS_DEPTH):0] ras_count
);

  localparam int unsigned      PTR_W      = $clog2(RAS_DEPTH);
  localparam int unsigned      CNT_W      = PTR_W + 1;
  localparam logic [WIDTH-1:0] ALIGN_MASK = ~WIDTH'(3);

  logic [WIDTH-1:0]                pc_q, pc_d;
  logic [WIDTH-1:0]                epc_q, epc_d;
  logic                            in_exc_q, in_exc_d;
  logic                            dfault_q, dfault_d;
  logic [PTR_W-1:0]                ptr_q, ptr_d;
  logic [CNT_W-1:0]                cnt_q, cnt_d;
  logic [RAS_DEPTH-1:0][WIDTH-1:0] ras_q, ras_d;
  logic [PTR_W-1:0]                top_idx;
  logic [WIDTH-1:0]                seq_pc;

  assign seq_pc  = pc_q + WIDTH'(4);
  assign top_idx = ptr_q - PTR_W'(1);

  // Next-state selection in strict priority order; losers have no side effects.
  always_comb begin
    pc_d     = pc_q;
    epc_d    = epc_q;
    in_exc_d = in_exc_q;
    dfault_d = dfault_q;
    ptr_d    = ptr_q;
    cnt_d    = cnt_q;
    ras_d    = ras_q;
    if (exception) begin
      pc_d = EXC_VECTOR & ALIGN_MASK;
      if (!in_exc_q) begin
        epc_d    = pc_q;
        in_exc_d = 1'b1;
      end else begin
        dfault_d = 1'b1;
      end
    end else if (!stall) begin
      if (eret && in_exc_q) begin
        pc_d     = epc_q & ALIGN_MASK;
        in_exc_d = 1'b0;
      end else if (branch_taken) begin
        pc_d = branch_target & ALIGN_MASK;
      end else if (ret) begin
        if (cnt_q != CNT_W'(0)) begin
          pc_d  = ras_q[top_idx] & ALIGN_MASK;
          ptr_d = top_idx;
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          pc_d = ret_target & ALIGN_MASK;
        end
      end else if (jump) begin
        pc_d = jump_target & ALIGN_MASK;
        if (call) begin
          // Circular push: when full, the write lands on the oldest entry.
          ras_d[ptr_q] = seq_pc & ALIGN_MASK;
          ptr_d        = ptr_q + PTR_W'(1);
          if (cnt_q != CNT_W'(RAS_DEPTH)) begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end else begin
        pc_d = seq_pc;
      end
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q     <= RESET_VECTOR;
      epc_q    <= '0;
      in_exc_q <= 1'b0;
      dfault_q <= 1'b0;
      ptr_q    <= '0;
      cnt_q    <= '0;
      ras_q    <= '0;
    end else begin
      pc_q     <= pc_d;
      epc_q    <= epc_d;
      in_exc_q <= in_exc_d;
      dfault_q <= dfault_d;
      ptr_q    <= ptr_d;
      cnt_q    <= cnt_d;
      ras_q    <= ras_d;
    end
  end

  assign pc_out       = pc_q;
  assign pc_plus4     = seq_pc;
  assign epc          = epc_q;
  assign in_exception = in_exc_q;
  assign double_fault = dfault_q;
  assign ras_count    = cnt_q;

endmodule

// File: tb/tb_pc_unit.sv
// Bench for pc_unit: directed program-flow scenarios then random redirects,
// all checked against a queue-based reference model.
module tb_pc_unit;

  localparam logic [31:0] RV  = 32'h0000_0000;
  localparam logic [31:0] EXC = 32'h8000_0180;
  localparam int          DEPTH = 4;

  logic        clk;
  logic        reset, stall, exception, eret, branch_taken, ret, jump, call;
  logic [31:0] branch_target, ret_target, jump_target;
  logic [31:0] pc_out, pc_plus4, epc;
  logic        in_exception, double_fault;
  logic [2:0]  ras_count;

  pc_unit #(
    .WIDTH(32), .RESET_VECTOR(RV), .EXC_VECTOR(EXC), .RAS_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .reset(reset), .stall(stall), .exception(exception), .eret(eret),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .ret(ret), .ret_target(ret_target),
    .jump(jump), .call(call), .jump_target(jump_target),
    .pc_out(pc_out), .pc_plus4(pc_plus4), .epc(epc),
    .in_exception(in_exception), .double_fault(double_fault), .ras_count(ras_count)
  );

  always #5 clk = ~clk;

  // Reference model state
  logic [31:0] m_pc, m_epc;
  logic        m_inx, m_df;
  logic [31:0] m_ras[$];

  int vectors    = 0;
  int miscompares = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_update();
    if (reset) begin
      m_pc = RV; m_epc = '0; m_inx = 1'b0; m_df = 1'b0;
      m_ras.delete();
    end else if (exception) begin
      if (!m_inx) begin
        m_epc = m_pc; m_inx = 1'b1;
      end else begin
        m_df = 1'b1;
      end
      m_pc = EXC;
    end else if (stall) begin
      // everything holds
    end else if (eret && m_inx) begin
      m_pc = m_epc; m_inx = 1'b0;
    end else if (branch_taken) begin
      m_pc = branch_target & ~32'd3;
    end else if (ret) begin
      if (m_ras.size() > 0) m_pc = m_ras.pop_back();
      else                  m_pc = ret_target & ~32'd3;
    end else if (jump) begin
      if (call) begin
        if (m_ras.size() == DEPTH) void'(m_ras.pop_front());
        m_ras.push_back((m_pc + 32'd4) & ~32'd3);
      end
      m_pc = jump_target & ~32'd3;
    end else begin
      m_pc = m_pc + 32'd4;
    end
  endtask

  task automatic check_all();
    check("pc_out",       pc_out,                 m_pc);
    check("pc_plus4",     pc_plus4,               m_pc + 32'd4);
    check("epc",          epc,                    m_epc);
    check("in_exception", 32'(in_exception),      32'(m_inx));
    check("double_fault", 32'(double_fault),      32'(m_df));
    check("ras_count",    32'(ras_count),         32'(m_ras.size()));
  endtask

  // One clock: model consumes current inputs, DUT samples them, outputs checked after the edge.
  task automatic step();
    model_update();
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic idle();
    reset = 0; stall = 0; exception = 0; eret = 0; branch_taken = 0;
    ret = 0; jump = 0; call = 0;
    branch_target = '0; ret_target = '0; jump_target = '0;
  endtask

  task automatic do_jump(input logic [31:0] tgt, input logic is_call);
    idle(); jump = 1; call = is_call; jump_target = tgt; step();
  endtask

  initial begin
    clk = 0;
    m_pc = '0; m_epc = '0; m_inx = 0; m_df = 0;
    idle();
    reset = 1; step();
    check("rst_pc", pc_out, 32'h0);
    idle(); step(); step(); step();
    check("free_pc_c", pc_out, 32'hC);
    step();
    // Stall masks a simultaneous branch
    idle(); stall = 1; branch_taken = 1; branch_target = 32'h100; step(); step();
    check("stall_pc", pc_out, 32'h10);
    idle(); step();
    check("unstall_pc", pc_out, 32'h14);
    // Branch wins over jump+call: no push
    do_jump(32'h20, 0);
    idle(); branch_taken = 1; branch_target = 32'h200;
    jump = 1; call = 1; jump_target = 32'h300; step();
    check("br_over_call", 32'(ras_count), 32'd0);
    do_jump(32'h300, 1);
    idle(); ret = 1; step();
    check("ret_pop", pc_out, 32'h204);
    idle(); ret = 1; ret_target = 32'h407; step();
    check("ret_empty", pc_out, 32'h404);
    // RAS overflow: 5 calls into a 4-deep stack
    do_jump(32'h0, 0);
    do_jump(32'h100, 1); do_jump(32'h200, 1); do_jump(32'h300, 1);
    do_jump(32'h400, 1); do_jump(32'h500, 1);
    check("ras_sat", 32'(ras_count), 32'd4);
    for (int i = 0; i < 5; i++) begin
      idle(); ret = 1; ret_target = 32'h777; step();
    end
    check("ras_5th_ret", pc_out, 32'h774);
    // Exception during stall, double fault, eret
    do_jump(32'h40, 0);
    idle(); exception = 1; stall = 1; step();
    check("exc_epc", epc, 32'h40);
    idle(); exception = 1; step();
    check("dfault", 32'(double_fault), 32'd1);
    idle(); eret = 1; step();
    check("eret_pc", pc_out, 32'h40);
    // eret outside handler falls through to sequential
    idle(); eret = 1; step();
    // Wrap-around and target alignment
    do_jump(32'hFFFF_FFFC, 0);
    idle(); step();
    check("wrap_pc", pc_out, 32'h0);
    do_jump(32'h123, 0);
    check("align_pc", pc_out, 32'h120);
    // Reset mid-handler discards state
    idle(); exception = 1; step();
    idle(); reset = 1; stall = 1; step();
    // Random redirect traffic
    for (int i = 0; i < 600; i++) begin
      idle();
      reset         = ($urandom_range(79) == 0);
      stall         = ($urandom_range(7) == 0);
      exception     = ($urandom_range(19) == 0);
      eret          = ($urandom_range(5) == 0);
      branch_taken  = ($urandom_range(6) == 0);
      ret           = ($urandom_range(4) == 0);
      jump          = ($urandom_range(3) == 0);
      call          = 1'($urandom_range(1));
      branch_target = $urandom;
      ret_target    = $urandom;
      jump_target   = $urandom;
      step();
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
